ext_pipe: RTL
=============

Name: ext_pipe

Overview:
- Parametrised successor to the combinational immediate extender.
- Accepts a WIDTH-bit field plus a mode code and produces an OUT_WIDTH-bit extended result. Modes are zero-extend, sign-extend, load-upper, and sign-extend with shift-left-2 for branch offsets.
- Registered output behind a 2-entry buffer with valid/ready handshakes on both sides, so it can sit between the decode and execute stages of the pipelined datapath.

Parameters:
- WIDTH, 16, input field width; legal range 1..OUT_WIDTH.
- OUT_WIDTH, 32, result width.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  producer presents a field.
- in_ready  output  1  block can accept; registered, equals (level < 2).
- in_a  input  WIDTH  field to extend.
- in_op  input  3  mode: 000 ZERO, 001 SIGN, 010 UPPER, 011 SIGN_SHL2; 100..111 illegal.
- out_valid  output  1  head entry present; equals (level != 0).
- out_ready  input  1  consumer takes head.
- out_b  output  OUT_WIDTH  extended result of head entry.
- out_err  output  1  head entry came from an illegal op; constant 0 unless EXT_ERR_EN.
- level  output  2  buffer occupancy, 0..2.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - level=0, out_valid=0, in_ready=1, out_b=0, out_err=0.
  - Stored entries are cleared to 0.
- Reset mid-operation: all buffered entries are discarded. Any handshake in the reset cycle is ignored.
- Push: occurs when in_valid && in_ready at a rising edge.
  - The result is computed combinationally from in_a/in_op and stored in the tail slot.
- Pop: occurs when out_valid && out_ready at a rising edge. The head advances.
- Latency: a push at edge N into an empty buffer gives out_valid=1 with that result during the cycle after edge N.
- Occupancy transitions:
  - level 0: push → 1.
  - level 1: push only → 2; pop only → 0; push+pop → 1, and the new entry becomes the head.
  - level 2: in_ready=0, so no push is possible; pop → 1.
- out_b and out_err hold stable while out_valid=1 && out_ready=0. The head is never overwritten.
- in_ready depends only on registered level, never combinationally on out_ready.
- Arithmetic, with s = in_a[WIDTH-1]:
  - ZERO: {(OUT_WIDTH-WIDTH) zeros, in_a}.
  - SIGN: {(OUT_WIDTH-WIDTH) copies of s, in_a}.
  - UPPER: in_a in bits [OUT_WIDTH-1:OUT_WIDTH-WIDTH], zeros below.
  - SIGN_SHL2: SIGN result shifted left by 2. The top 2 bits are discarded and the low 2 bits are 0.
- WIDTH==OUT_WIDTH: ZERO, SIGN and UPPER all return in_a unchanged.
- Illegal op: behaviour is set by EXT_ERR_EN (see Optional Feature).

Optional Feature:
- Macro: EXT_ERR_EN.
- Defined:
  - Illegal in_op (100..111) stores out_b=0 and out_err=1 for that entry.
  - Legal ops store out_err=0.
  - The entry still occupies a slot and is popped normally.
- Undefined:
  - Illegal ops are treated as ZERO.
  - out_err is tied to 0 and carries no storage.

Test Plan:
1. Reset, then push in_a=16'h8001 with SIGN, out_ready=1 → next cycle out_valid=1, out_b=32'hFFFF8001. Then level returns to 0.
2. Push 16'h8001 with ZERO, then UPPER, then SIGN_SHL2, on back-to-back cycles with out_ready=1 → out_b sequence is 32'h00008001, 32'h80010000, 32'hFFFE0004, one per cycle, with level staying 1 throughout.
3. Hold out_ready=0 and push 16'h0001 then 16'h0002 (ZERO) → level=2, in_ready=0. A third push with in_valid=1 is not accepted. out_b holds 32'h00000001. Raising out_ready pops 1 then 2.
4. At level=1, push and pop in the same cycle → level stays 1, and the new entry's result appears as head next cycle.
5. Fill to level=2, assert reset for one cycle → level=0, out_valid=0, in_ready=1, out_b=0. No stale entries appear afterwards.
6. Push in_op=3'b101 with in_a=16'h1234 → with EXT_ERR_EN: out_b=0, out_err=1. Without it: out_b=32'h00001234, out_err=0.

Source files
------------

// File: rtl/ext_pipe.sv
// Immediate extender (zero / sign / upper / sign<<2) behind a 2-entry valid/ready buffer.
// Define EXT_ERR_EN to flag illegal mode codes through out_err instead of treating them as ZERO.
module ext_pipe #(
    parameter int WIDTH     = 16,
    parameter int OUT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [2:0]           in_op,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_b,
    output logic                 out_err,
    output logic [1:0]           level
);

    localparam int SHAMT = OUT_WIDTH - WIDTH;

    localparam logic [2:0] OP_ZERO      = 3'b000;
    localparam logic [2:0] OP_SIGN      = 3'b001;
    localparam logic [2:0] OP_UPPER     = 3'b010;
    localparam logic [2:0] OP_SIGN_SHL2 = 3'b011;

    function automatic logic [OUT_WIDTH-1:0] extend_f(input logic [WIDTH-1:0] a,
                                                      input logic [2:0]       op);
        logic signed [WIDTH-1:0]     sa;
        logic signed [OUT_WIDTH-1:0] sx;
        logic [OUT_WIDTH-1:0]        zx;
        sa = signed'(a);
        sx = sa;
        zx = OUT_WIDTH'(a);
        case (op)
            OP_ZERO:      extend_f = zx;
            OP_SIGN:      extend_f = sx;
            OP_UPPER:     extend_f = zx << SHAMT;
            OP_SIGN_SHL2: extend_f = sx << 2;
`ifdef EXT_ERR_EN
            default:      extend_f = '0;
`else
            default:      extend_f = zx;
`endif
        endcase
    endfunction

    logic [1:0]           level_q, level_d;
    logic                 in_ready_q, in_ready_d;
    logic [OUT_WIDTH-1:0] b0_q, b0_d, b1_q, b1_d;
    logic [OUT_WIDTH-1:0] new_b;
    logic                 push, pop;
`ifdef EXT_ERR_EN
    logic                 e0_q, e0_d, e1_q, e1_d;
    logic                 new_e;
    assign new_e = in_op[2];
`endif

    assign push  = in_valid && in_ready_q;
    assign pop   = (level_q != 2'd0) && out_ready;
    assign new_b = extend_f(in_a, in_op);

    // Slot 0 is always the head; slot 1 only holds data while level is 2.
    always_comb begin
        level_d = level_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
`ifdef EXT_ERR_EN
        e0_d    = e0_q;
        e1_d    = e1_q;
`endif
        case (level_q)
            2'd0: begin
                if (push) begin
                    b0_d    = new_b;
`ifdef EXT_ERR_EN
                    e0_d    = new_e;
`endif
                    level_d = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    b0_d = new_b;
`ifdef EXT_ERR_EN
                    e0_d = new_e;
`endif
                end else if (push) begin
                    b1_d    = new_b;
`ifdef EXT_ERR_EN
                    e1_d    = new_e;
`endif
                    level_d = 2'd2;
                end else if (pop) begin
                    level_d = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    b0_d    = b1_q;
`ifdef EXT_ERR_EN
                    e0_d    = e1_q;
`endif
                    level_d = 2'd1;
                end
            end
        endcase
        in_ready_d = (level_d != 2'd2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q    <= 2'd0;
            in_ready_q <= 1'b1;
            b0_q       <= '0;
            b1_q       <= '0;
`ifdef EXT_ERR_EN
            e0_q       <= 1'b0;
            e1_q       <= 1'b0;
`endif
        end else begin
            level_q    <= level_d;
            in_ready_q <= in_ready_d;
            b0_q       <= b0_d;
            b1_q       <= b1_d;
`ifdef EXT_ERR_EN
            e0_q       <= e0_d;
            e1_q       <= e1_d;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (level_q != 2'd0);
    assign out_b     = b0_q;
    assign level     = level_q;
`ifdef EXT_ERR_EN
    assign out_err   = e0_q;
`else
    assign out_err   = 1'b0;
`endif

endmodule
